pwm_dac: RTL and testbench

PWM_DAC -- requirements
Module: pwm_dac

---
 rtl/pwm_dac.sv | 154 +++++++++++++++
 tb/tb_pwm_dac.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// pwm_dac: 8-bit PWM DAC with gain scaling, single-sample pending buffer,
// sticky overrun flag and a graceful-stop state machine.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - synchronous, active-high reset
//   sample_in    - offset-binary sample (MID = zero)
//   sample_valid - qualifies sample_in for one cycle
//   gain         - amplitude in 1/16 steps, 17..31 clamp to 16
//   enable       - requests PWM operation
//   clr_ovr      - clears the overrun flag
//   pwm_out      - registered PWM bit
//   period_start - one-cycle pulse on the first cycle of a running period
//   overrun      - sticky sample-overrun flag
//   busy         - high in RUN and STOP
module pwm_dac #(
    parameter logic [7:0] MID = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic [4:0] gain,
    input  logic       enable,
    input  logic       clr_ovr,
    output logic       pwm_out,
    output logic       period_start,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_cnt;
    logic [7:0]  r_duty;
    logic [7:0]  r_pend;
    logic        r_pend_full;
    logic        r_ovr;
    logic        r_pwm;
    logic        r_ps;

    logic        w_last;
    logic        w_consume;
    logic        w_ovr_set;
    logic [4:0]  w_g;
    logic signed [8:0]  w_diff;
    logic signed [14:0] w_prod;
    logic signed [10:0] w_step;
    logic signed [10:0] w_sum;
    logic [7:0]  w_scaled;

    assign w_last    = (r_cnt == 8'hFF);
    assign w_consume = (r_state == RUN) && w_last && r_pend_full;
    assign w_ovr_set = sample_valid && r_pend_full && !w_consume;

    // Signed deviation from MID, scaled by g/16 with floor rounding.
    // The sum is clamped so a non-default MID can never wrap.
    assign w_g    = (gain > 5'd16) ? 5'd16 : gain;
    assign w_diff = $signed({1'b0, r_pend}) - $signed({1'b0, MID});
    assign w_prod = w_diff * $signed({1'b0, w_g});
    assign w_step = w_prod[14:4];
    assign w_sum  = $signed({3'b000, MID}) + w_step;

    always_comb begin
        w_scaled = w_sum[7:0];
        if (w_sum < 0) begin
            w_scaled = 8'h00;
        end else if (w_sum > 11'sd255) begin
            w_scaled = 8'hFF;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (enable) w_next = RUN;
            end
            RUN: begin
                if (!enable) w_next = w_last ? IDLE : STOP;
            end
            STOP: begin
                if (enable)      w_next = RUN;
                else if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state == RUN) || (r_state == STOP);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 8'h00;
            r_duty      <= MID;
            r_pend      <= MID;
            r_pend_full <= 1'b0;
            r_ovr       <= 1'b0;
            r_pwm       <= 1'b0;
            r_ps        <= 1'b0;
        end else begin
            r_cnt <= (r_state == IDLE) ? 8'h00 : r_cnt + 8'd1;

            if (r_state == IDLE) begin
                r_duty <= MID;
            end else if (w_consume) begin
                r_duty <= w_scaled;
            end

            // A new sample in the consume cycle keeps the buffer full.
            if (sample_valid) begin
                r_pend      <= sample_in;
                r_pend_full <= 1'b1;
            end else if (w_consume) begin
                r_pend_full <= 1'b0;
            end

            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr <= 1'b0;
            end

            r_pwm <= (r_state != IDLE) && (r_cnt < r_duty);
            r_ps  <= (w_next == RUN) && ((r_state == IDLE) || w_last);
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_ps;
    assign overrun      = r_ovr;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed checks of pwm_dac duty, scaling, overrun,
// stop/restart and reset behaviour.
module tb_pwm_dac;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic [4:0] gain;
    logic       enable;
    logic       clr_ovr;
    logic       pwm_out;
    logic       period_start;
    logic       overrun;
    logic       busy;

    int n_pass;
    int n_total;
    int hi;
    int ps;

    pwm_dac #(.MID(8'h80)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .gain         (gain),
        .enable       (enable),
        .clr_ovr      (clr_ovr),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic to_cnt(input logic [7:0] v);
        int n;
        n = 0;
        while (dut.r_cnt != v && n < 600) begin
            step();
            n++;
        end
        if (n >= 600) check("to_cnt_timeout", 1, 0);
    endtask

    task automatic measure(output int h, output int p);
        h = 0;
        p = 0;
        for (int i = 0; i < 256; i++) begin
            h += int'(pwm_out);
            p += int'(period_start);
            step();
        end
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst          = 1'b1;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        gain         = 5'd16;
        enable       = 1'b0;
        clr_ovr      = 1'b0;
        step();
        step();

        check("rst_pwm", int'(pwm_out), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_duty", int'(dut.r_duty), 128);
        check("rst_cnt", int'(dut.r_cnt), 0);

        rst    = 1'b0;
        enable = 1'b1;
        step();
        check("start_ps", int'(period_start), 1);
        check("start_busy", int'(busy), 1);
        check("start_cnt", int'(dut.r_cnt), 0);

        measure(hi, ps);
        check("p1_high", hi, 128);
        check("p1_ps", ps, 1);
        measure(hi, ps);
        check("p2_high", hi, 128);
        check("p2_ps", ps, 1);

        pulse(8'hFF);
        to_cnt(8'h00);
        check("g16_duty", int'(dut.r_duty), 255);
        measure(hi, ps);
        check("g16_high", hi, 255);

        gain = 5'd8;
        pulse(8'hFF);
        to_cnt(8'h00);
        check("g8_ff_duty", int'(dut.r_duty), 191);
        measure(hi, ps);
        check("g8_ff_high", hi, 191);

        pulse(8'h00);
        to_cnt(8'h00);
        check("g8_00_duty", int'(dut.r_duty), 64);

        gain = 5'd31;
        pulse(8'h00);
        to_cnt(8'h00);
        check("g31_duty", int'(dut.r_duty), 0);
        measure(hi, ps);
        check("duty0_high", hi, 0);

        gain = 5'd16;
        pulse(8'h10);
        repeat (10) step();
        check("one_sample_ovr", int'(overrun), 0);
        pulse(8'h30);
        check("ovr_set", int'(overrun), 1);
        to_cnt(8'h00);
        check("ovr_duty", int'(dut.r_duty), 48);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_clr", int'(overrun), 0);

        pulse(8'h50);
        clr_ovr = 1'b1;
        pulse(8'h60);
        clr_ovr = 1'b0;
        check("ovr_wins_clr", int'(overrun), 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_clr2", int'(overrun), 0);

        to_cnt(8'hFF);
        pulse(8'h90);
        check("edge_duty", int'(dut.r_duty), 96);
        check("edge_pend", int'(dut.r_pend), 144);
        check("edge_full", int'(dut.r_pend_full), 1);
        check("edge_ovr", int'(overrun), 0);
        to_cnt(8'hFF);
        step();
        check("edge_next_duty", int'(dut.r_duty), 144);

        to_cnt(8'd100);
        enable = 1'b0;
        step();
        check("stop_busy", int'(busy), 1);
        check("stop_cnt", int'(dut.r_cnt), 101);
        to_cnt(8'hFF);
        step();
        check("idle_busy", int'(busy), 0);
        check("idle_pwm", int'(pwm_out), 0);
        check("idle_ps", int'(period_start), 0);
        step();
        check("idle_pwm2", int'(pwm_out), 0);
        check("idle_duty", int'(dut.r_duty), 128);
        check("idle_cnt", int'(dut.r_cnt), 0);

        enable = 1'b1;
        step();
        check("restart_ps", int'(period_start), 1);
        to_cnt(8'd100);
        enable = 1'b0;
        step();
        to_cnt(8'd200);
        enable = 1'b1;
        step();
        check("resume_busy", int'(busy), 1);
        check("resume_cnt", int'(dut.r_cnt), 201);
        ps = 0;
        for (int i = 0; i < 60 && dut.r_cnt != 8'h00; i++) begin
            ps += int'(period_start);
            step();
        end
        check("resume_no_ps", ps, 0);
        check("resume_wrap_cnt", int'(dut.r_cnt), 0);
        check("resume_wrap_ps", int'(period_start), 1);
        check("resume_wrap_busy", int'(busy), 1);

        pulse(8'hC0);
        to_cnt(8'hFF);
        step();
        check("c0_duty", int'(dut.r_duty), 192);
        pulse(8'h11);
        pulse(8'h22);
        check("pre_rst_ovr", int'(overrun), 1);
        to_cnt(8'd50);
        rst = 1'b1;
        step();
        check("mid_rst_pwm", int'(pwm_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_duty", int'(dut.r_duty), 128);
        check("mid_rst_ovr", int'(overrun), 0);
        check("mid_rst_cnt", int'(dut.r_cnt), 0);
        check("mid_rst_full", int'(dut.r_pend_full), 0);
        rst    = 1'b0;
        enable = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
